// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle load/store sequencer between the execute stage
// and a handshaked data memory port.
module lsu_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;

    logic              is_b;
    logic              is_h;
    logic              is_w;
    logic              ld_ok;
    logic              st_ok;
    logic              misalign;
    logic              req_bad;
    logic [3:0]        be_c;
    logic [DATA_W-1:0] wd_c;

    // Byte/halfword loads are shifted down to lane 0, then extended.
    function automatic logic [DATA_W-1:0] load_ext(
        input logic [2:0]        f3,
        input logic [1:0]        off,
        input logic [DATA_W-1:0] w
    );
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] r;
        sh = w >> {off, 3'b000};
        unique case (f3)
            3'b000:  r = {{(DATA_W-8){sh[7]}}, sh[7:0]};
            3'b001:  r = {{(DATA_W-16){sh[15]}}, sh[15:0]};
            3'b100:  r = {{(DATA_W-8){1'b0}}, sh[7:0]};
            3'b101:  r = {{(DATA_W-16){1'b0}}, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        is_b     = (req_funct3[1:0] == 2'b00);
        is_h     = (req_funct3[1:0] == 2'b01);
        is_w     = (req_funct3[1:0] == 2'b10);
        ld_ok    = is_b | is_h | (is_w & ~req_funct3[2]);
        st_ok    = ~req_funct3[2] & (is_b | is_h | is_w);
        misalign = (is_h & req_addr[0])
                 | (is_w & (req_addr[1:0] != 2'b00));
        req_bad  = (req_we ? ~st_ok : ~ld_ok) | misalign;
    end

    always_comb begin
        be_c = 4'b1111;
        wd_c = req_wdata;
        unique case (1'b1)
            is_b: begin
                be_c = 4'b0001 << req_addr[1:0];
                wd_c = {4{req_wdata[7:0]}};
            end
            is_h: begin
                be_c = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{req_wdata[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = req_wdata;
            end
        endcase
    end

    // Reset is folded in so the pipeline unfreezes without a clock edge.
    assign stall = rst_n & (((state == IDLE) & req_valid)
                 | (state == REQ) | (state == WAIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q  <= req_we;
                        f3_q  <= req_funct3;
                        off_q <= req_addr[1:0];
                        if (req_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= req_we ? wd_c : '0;
                        end
                    end
                end
                REQ: begin
                    if (cnt == CNT_LAST) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (mem_gnt) begin
                            state <= WAIT;
                        end
                    end
                    if ((cnt == CNT_LAST) || mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= '0;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (mem_rvalid) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= we_q ? '0
                                   : load_ext(f3_q, off_q, mem_rdata);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vectors for lsu_ctrl, with a second instance
// built with a short timeout.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        sel_to;
    logic        rv_main;
    logic        rv_to;

    logic        m_stall, m_rsp_valid, m_rsp_err, m_mem_req, m_mem_we;
    logic [31:0] m_rsp_rdata, m_mem_addr, m_mem_wdata;
    logic [3:0]  m_mem_be;
    logic        t_stall, t_rsp_valid, t_rsp_err, t_mem_req, t_mem_we;
    logic [31:0] t_rsp_rdata, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_be;

    logic        w_stall, w_rsp_valid, w_rsp_err, w_mem_req, w_mem_we;
    logic [31:0] w_rsp_rdata, w_mem_addr, w_mem_wdata;
    logic [3:0]  w_mem_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rv_main = req_valid & ~sel_to;
    assign rv_to   = req_valid & sel_to;

    assign w_stall     = sel_to ? t_stall     : m_stall;
    assign w_rsp_valid = sel_to ? t_rsp_valid : m_rsp_valid;
    assign w_rsp_err   = sel_to ? t_rsp_err   : m_rsp_err;
    assign w_rsp_rdata = sel_to ? t_rsp_rdata : m_rsp_rdata;
    assign w_mem_req   = sel_to ? t_mem_req   : m_mem_req;
    assign w_mem_we    = sel_to ? t_mem_we    : m_mem_we;
    assign w_mem_addr  = sel_to ? t_mem_addr  : m_mem_addr;
    assign w_mem_be    = sel_to ? t_mem_be    : m_mem_be;
    assign w_mem_wdata = sel_to ? t_mem_wdata : m_mem_wdata;

    lsu_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv_main), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .stall(m_stall), .rsp_valid(m_rsp_valid),
        .rsp_rdata(m_rsp_rdata), .rsp_err(m_rsp_err),
        .mem_req(m_mem_req), .mem_we(m_mem_we),
        .mem_addr(m_mem_addr), .mem_be(m_mem_be),
        .mem_wdata(m_mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    lsu_ctrl #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(rv_to), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .stall(t_stall), .rsp_valid(t_rsp_valid),
        .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err),
        .mem_req(t_mem_req), .mem_we(t_mem_we),
        .mem_addr(t_mem_addr), .mem_be(t_mem_be),
        .mem_wdata(t_mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One transaction; the responder grants after gdly request cycles
    // and returns read data in the first WAIT cycle.
    task automatic op(input bit          to,
                      input logic        we,
                      input logic [2:0]  f3,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [31:0] rdata,
                      input int          gdly,
                      input logic [3:0]  ebe,
                      input logic [31:0] ewd,
                      input logic [31:0] erd,
                      input logic        eerr,
                      input int          elat,
                      input int          enreq,
                      input string       tag);
        int  reqc;
        int  lat;
        bit  done;
        @(negedge clk);
        sel_to     = to;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_rdata  = rdata;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        #1 check({tag, ".stall0"}, w_stall, 1);
        reqc = 0;
        lat  = -1;
        done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            #1;
            if (w_rsp_valid) begin
                lat       = c;
                done      = 1'b1;
                req_valid = 1'b0;
                check({tag, ".rdata"}, w_rsp_rdata, erd);
                check({tag, ".err"}, w_rsp_err, eerr);
                check({tag, ".rstall"}, w_stall, 0);
                check({tag, ".rreq"}, w_mem_req, 0);
                check({tag, ".rbe"}, w_mem_be, 0);
            end else if (w_mem_req) begin
                if (reqc == 0) begin
                    check({tag, ".addr"}, w_mem_addr, addr & 32'hFFFF_FFFC);
                    check({tag, ".be"}, w_mem_be, ebe);
                    check({tag, ".we"}, w_mem_we, we);
                    check({tag, ".qstall"}, w_stall, 1);
                    if (we) check({tag, ".wdata"}, w_mem_wdata, ewd);
                end
                if (reqc == gdly) mem_gnt = 1'b1;
                reqc++;
            end else if (w_stall && reqc > 0) begin
                mem_rvalid = 1'b1;
            end
        end
        req_valid  = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check({tag, ".lat"}, lat, elat);
        check({tag, ".nreq"}, reqc, enreq);
        @(negedge clk);
        #1;
        check({tag, ".pulse"}, w_rsp_valid, 0);
        check({tag, ".idle"}, w_stall, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        sel_to     = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst.req", m_mem_req, 0);
        check("rst.rsp", m_rsp_valid, 0);
        check("rst.stall", m_stall, 0);
        check("rst.be", m_mem_be, 0);
        check("rst.addr", m_mem_addr, 0);
        rst_n = 1'b1;

        op(0, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0,
           4'b1111, 0, 32'hDEADBEEF, 0, 3, 1, "lw");
        op(0, 0, 3'b000, 32'h103, 0, 32'h80FF7F01, 0,
           4'b1000, 0, 32'hFFFFFF80, 0, 3, 1, "lb");
        op(0, 0, 3'b100, 32'h103, 0, 32'h80FF7F01, 0,
           4'b1000, 0, 32'h00000080, 0, 3, 1, "lbu");
        op(0, 0, 3'b001, 32'h102, 0, 32'h80017FFF, 0,
           4'b1100, 0, 32'hFFFF8001, 0, 3, 1, "lh");
        op(0, 0, 3'b101, 32'h100, 0, 32'h80017FFF, 0,
           4'b0011, 0, 32'h00007FFF, 0, 3, 1, "lhu");
        op(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, 3,
           4'b1100, 32'hABCDABCD, 0, 0, 6, 4, "sh");
        op(0, 1, 3'b000, 32'h101, 32'h000000A5, 32'h55555555, 0,
           4'b0010, 32'hA5A5A5A5, 0, 0, 3, 1, "sb");
        op(0, 1, 3'b010, 32'h10C, 32'h01234567, 32'h55555555, 0,
           4'b1111, 32'h01234567, 0, 0, 3, 1, "sw");
        op(0, 0, 3'b010, 32'h101, 0, 0, 0,
           4'b0000, 0, 0, 1, 1, 0, "lw_mis");
        op(0, 0, 3'b011, 32'h100, 0, 0, 0,
           4'b0000, 0, 0, 1, 1, 0, "ld_ill");
        op(0, 1, 3'b100, 32'h100, 32'hFFFFFFFF, 0, 0,
           4'b0000, 0, 0, 1, 1, 0, "st_ill");
        op(0, 1, 3'b001, 32'h203, 32'hFFFFFFFF, 0, 0,
           4'b0000, 0, 0, 1, 1, 0, "sh_mis");
        op(1, 0, 3'b010, 32'h400, 0, 32'h12345678, 100,
           4'b1111, 0, 0, 1, 5, 4, "tmo");

        @(negedge clk);
        sel_to     = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h300;
        @(negedge clk);
        #1 check("ar.req", m_mem_req, 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        #1 check("ar.wait", {m_mem_req, m_stall}, 2'b01);
        rst_n = 1'b0;
        #1;
        check("ar.mreq", m_mem_req, 0);
        check("ar.stall", m_stall, 0);
        check("ar.rsp", m_rsp_valid, 0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        #1 check("ar.idle", m_stall, 0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11111111;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("stale.rsp", m_rsp_valid, 0);
        check("stale.req", m_mem_req, 0);
        op(0, 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 0,
           4'b1111, 0, 32'hCAFEF00D, 0, 3, 1, "lw_post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Multi-cycle load/store sequencer between the core's execute stage and a handshaked data memory port.
- Accepts one load or store per transaction. The control unit's dm_en selects store; funct3 selects width and sign.
- Generates byte enables and lane-shifted write data, stalls the pipeline until the memory responds, then returns extended load data.
- Flags misaligned or illegal accesses and memory timeouts as errors.

Parameters:
- DATA_W, 32, data path width; only 32 is supported.
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before an error is raised; must be >= 2.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset: asynchronous assert, active-low; one clock, asynchronous active-low reset.
- req_valid  in  1  memory op pending; req_* held stable while stall=1.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  ADDR_W  byte address (ALU result).
- req_wdata  in  DATA_W  store data (rs2).
- stall  out  1  freeze the pipeline.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and on error.
- rsp_err  out  1  valid with rsp_valid: misaligned, illegal funct3, or timeout.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_W  lane-replicated write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data / write ack valid.
- mem_rdata  in  DATA_W  read data word.

Behaviour:
- Reset: state=IDLE, counter=0, all outputs 0, request latches 0. Asserting rst_n low mid-transaction forces IDLE immediately; mem_req drops without waiting for a clock edge.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If req_valid: latch we/funct3/addr/wdata.
  - Illegal funct3 or misaligned access -> RESP with err=1; no memory access.
  - Otherwise -> REQ.
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- REQ: mem_req=1 with latched fields. mem_gnt -> WAIT.
- WAIT: mem_req=0. mem_rvalid -> RESP; capture mem_rdata. A write also completes on mem_rvalid. mem_rvalid seen in any other state is ignored.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - On reaching TIMEOUT -> RESP with err=1; mem_req drops.
  - Timeout has priority over gnt/rvalid arriving in the same cycle.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE. A new request may be accepted in the following IDLE cycle.
- stall = (IDLE & req_valid) | REQ | WAIT. stall is low in RESP, so the pipeline advances on the rsp_valid cycle.
- Minimum latency with gnt and rvalid immediate: accept at cycle 0, REQ cycle 1, WAIT cycle 2, rsp_valid cycle 3. Error latency: rsp_valid at cycle 1.
- Byte enables and write data, off=addr[1:0]:
  - SB: be=1<<off, wdata={4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
  - mem_be and mem_wdata are 0 when mem_req=0.
  - Loads drive mem_we=0 and be per width.
- Load extraction from the captured word at off:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes through unchanged.
- rsp_rdata and rsp_err are 0 whenever rsp_valid=0.

Test Plan:
- LW addr 0x100, gnt at REQ cycle 1, rvalid at WAIT cycle 1, mem_rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, rsp_valid on cycle 3, rsp_rdata 0xDEADBEEF, err 0, stall high cycles 0-2.
- LB addr 0x103, rdata 0x80FF7F01 -> be 1000, rsp_rdata 0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD, gnt delayed 3 cycles -> mem_req held 4 cycles, be 1100, mem_wdata 0xABCDABCD, mem_we 1, rsp_rdata 0.
- LW addr 0x101 -> no mem_req, rsp_valid on cycle 1 with err 1. funct3=011 load -> same error response.
- TIMEOUT=4, gnt never asserted -> mem_req high 4 cycles then low, rsp_valid with err 1.
- rst_n pulled low while in WAIT -> mem_req, stall, and rsp_valid immediately 0. After release, a subsequent LW completes normally; a stale rvalid arriving in IDLE is ignored.
